// File: rtl/ch_fifo_if.sv
// ch_fifo_if: enqueue/dequeue ready-valid bundle with flush and occupancy status.
// The FIFO takes the slave modport; the producer/consumer side takes master.
interface ch_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                  flush;
  logic                  enq_valid;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  enq_ready;
  logic                  deq_valid;
  logic [DATA_WIDTH-1:0] deq_data;
  logic                  deq_ready;
  logic [AW:0]           size;
  logic                  almost_full;
  logic                  almost_empty;

  modport slave (
    input  flush, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, size, almost_full, almost_empty
  );

  modport master (
    output flush, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, size, almost_full, almost_empty
  );
endinterface

// File: rtl/ch_fifo.sv
// ch_fifo: parametrised single-clock ready/valid FIFO with synchronous flush,
// almost-full/almost-empty thresholds and an optional empty-bypass path.
// Optional feature macro: CH_FIFO_BYPASS_EN (when defined, an empty FIFO
// forwards the enqueue word straight to the dequeue side in the same cycle).
module ch_fifo #(
  parameter int DATA_WIDTH   = 4,
  parameter int DEPTH        = 2,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic     clk,
  input  logic     reset,
  ch_fifo_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_LEVEL);

  // Storage is intentionally not reset; validity is tracked by the pointers.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           size_s;
  logic                  empty_s, full_s, clear_s;
  logic                  bypass_s, pass_s;
  logic                  enq_fire_s, deq_fire_s, mem_we_s;

  // Status derived from the registered pointers, plus the bypass qualifier.
  always_comb begin
    clear_s = reset | io.flush;
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    size_s  = wr_ptr_q - rd_ptr_q;
`ifdef CH_FIFO_BYPASS_EN
    bypass_s = empty_s & io.enq_valid & ~clear_s;
`else
    bypass_s = 1'b0;
`endif
    pass_s = bypass_s & io.deq_ready;
  end

  // Output decode: handshake flags, head data (or bypassed word) and occupancy.
  always_comb begin
    io.enq_ready    = ~full_s;
    io.deq_valid    = ~empty_s | bypass_s;
    if (bypass_s) begin
      io.deq_data = io.enq_data;
    end else begin
      io.deq_data = mem_q[rd_ptr_q[AW-1:0]];
    end
    io.size         = size_s;
    io.almost_full  = (size_s >= AFULL_LVL);
    io.almost_empty = (size_s <= AEMPTY_LVL);
  end

  // Next-state pointers: reset/flush clear everything, a passed-through word
  // leaves state untouched, otherwise each side advances on its handshake.
  always_comb begin
    enq_fire_s = io.enq_valid & ~full_s;
    deq_fire_s = ~empty_s & io.deq_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_we_s   = 1'b0;
    if (clear_s) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else if (pass_s) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
    end else begin
      mem_we_s = enq_fire_s;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, enq_fire_s};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, deq_fire_s};
    end
  end

  // Pointer registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write at the write index on an accepted, non-discarded enqueue.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= io.enq_data;
    end
  end
endmodule

// File: doc/ch_fifo.md
# ch_fifo

Parametrised synchronous FIFO: the next generation of the two-entry `ch_queue`. Generalises data width and depth, and adds a synchronous flush, occupancy thresholds and an optional empty-bypass path. Used as the standard ready/valid decoupling buffer between producer and consumer blocks in the same clock domain.

## Interface
- `DATA_WIDTH`, 4, payload width in bits (≥1)
- `DEPTH`, 2, number of entries; power of two, ≥2
- `AFULL_LEVEL`, DEPTH-1, `io_almost_full` asserts when occupancy ≥ this value (1..DEPTH)
- `AEMPTY_LEVEL`, 1, `io_almost_empty` asserts when occupancy ≤ this value (0..DEPTH-1)

Let AW = log2(DEPTH).
- `clk` in 1: the single clock, rising edge
- `reset` in 1: synchronous, active-high; clears pointers
- `io_flush` in 1: synchronous clear of contents; same effect as reset on pointers
- `io_enq_valid` in 1: producer has data
- `io_enq_data` in DATA_WIDTH: enqueue payload
- `io_enq_ready` out 1: FIFO accepts data (not full)
- `io_deq_valid` out 1: head data available
- `io_deq_data` out DATA_WIDTH: head payload
- `io_deq_ready` in 1: consumer takes head
- `io_size` out AW+1: current occupancy, 0..DEPTH
- `io_almost_full` out 1: occupancy ≥ AFULL_LEVEL
- `io_almost_empty` out 1: occupancy ≤ AEMPTY_LEVEL

## Operation
- Storage: DEPTH × DATA_WIDTH register array; not reset; combinational read at read index.
- Pointers `wr_ptr`, `rd_ptr`, each AW+1 bits; low AW bits index storage, MSB is the wrap bit. Increment modulo 2^(AW+1).
- Empty: `wr_ptr == rd_ptr`. Full: low AW bits equal and MSBs differ.
- `io_size = wr_ptr - rd_ptr` (AW+1-bit modular subtract), so exactly DEPTH when full.
- `io_enq_ready = !full`; no combinational dependence on `io_deq_ready`. When full, an enqueue is refused even if a dequeue happens in the same cycle.
- `io_deq_valid = !empty`; `io_deq_data = mem[rd_ptr[AW-1:0]]`. Data is X/stale when `io_deq_valid`=0.
- Enqueue fires when `io_enq_valid && io_enq_ready`: write `mem[wr_ptr]`, increment `wr_ptr`.
- Dequeue fires when `io_deq_valid && io_deq_ready`: increment `rd_ptr`.
- Simultaneous enqueue and dequeue (non-empty, non-full): both fire, size unchanged.
- Valid without ready on either side: no state change; producer holds data, which the FIFO does not sample.
- Priority: `reset` > `io_flush` > normal operation. In a reset or flush cycle both pointers go to 0 and any enqueue/dequeue in that cycle is discarded.

## Timing
- Enqueue to `io_deq_valid`: 1 cycle (data written at edge N, visible after edge N), unless bypass is enabled.
- `io_size`, `io_almost_*`, `io_enq_ready`, `io_deq_valid` all update at the edge following the handshake; all are combinational from the registered pointers.
- Values after reset: `io_enq_ready`=1, `io_deq_valid`=0, `io_size`=0, `io_almost_empty`=1, `io_almost_full`=0. `io_deq_data` is undefined.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Configuration
- `CH_FIFO_BYPASS_EN` defined: when empty, `io_deq_valid = io_enq_valid` and `io_deq_data = io_enq_data` combinationally. If `io_deq_ready` is also high, the word passes through and is not written: pointers and size are unchanged. If `io_deq_ready` is low, the word is written normally. Bypass is suppressed in reset and flush cycles, where `io_deq_valid`=0. Occupancy flags ignore bypassed words.
- `CH_FIFO_BYPASS_EN` undefined: no bypass; enqueue-to-dequeue latency is 1 cycle, as above.

## Test plan
- DATA_WIDTH=8, DEPTH=4: enqueue 0x11,0x22,0x33,0x44 with deq_ready=0. Size steps 1..4, enq_ready=0 after the 4th, almost_full=1 from size 3. Then drain: data out 0x11..0x44 in order, deq_valid=0 at size 0.
- Wrap-around: 10 cycles of continuous enq+deq of an incrementing pattern. Output matches input with 1-cycle latency. Size stays 1; no data loss across the pointer MSB toggle.
- Full plus simultaneous: FIFO full, enq_valid=1 and deq_ready=1. Dequeue fires, enqueue is refused. Size becomes 3, the refused word is absent from later output.
- Flush: at size 3, assert io_flush with enq_valid=1. Next cycle size=0, deq_valid=0, enq_ready=1. Later output excludes the flushed and the same-cycle words.
- Reset mid-operation: at size 2, assert reset for 1 cycle. All outputs return to their reset values; a following enqueue of 0x5A dequeues as 0x5A.
- With `CH_FIFO_BYPASS_EN`: empty, enq 0x7E with deq_ready=1. deq_valid=1 and deq_data=0x7E in the same cycle, size stays 0. Repeat with deq_ready=0: size becomes 1.
